// File: rtl/gcu_task_sched.sv
// gcu_task_sched: dependency-tracking task table that dispatches descriptors whose children have all completed
module gcu_task_sched #(
  parameter int ADDR_W      = 4,
  parameter int DIM_W       = 4,
  parameter int NODE_ID_W   = 4,
  parameter int CHILD_CNT_W = 4,
  parameter int FLAGS_W     = 4,
  parameter int RR_MODE     = 0,
  localparam int TASK_W = 2*DIM_W + 2*NODE_ID_W + CHILD_CNT_W + FLAGS_W + 5*ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   task_in_valid,
  output logic                   task_in_ready,
  input  logic [TASK_W-1:0]      task_in_data,
  output logic                   task_out_valid,
  input  logic                   task_out_ready,
  output logic [TASK_W-1:0]      task_out_data,
  input  logic                   done_valid,
  input  logic [NODE_ID_W-1:0]   done_id,
  output logic [NODE_ID_W:0]     occupancy,
  output logic                   root_done,
  output logic                   err_dup,
  output logic                   err_orphan,
  output logic                   err_done
);
  localparam int N      = 1 << NODE_ID_W;
  localparam int OW     = NODE_ID_W + 1;
  localparam int CC_LSB = 5*ADDR_W + FLAGS_W;
  localparam int PA_LSB = CC_LSB + CHILD_CNT_W;
  localparam int ID_LSB = PA_LSB + NODE_ID_W;
  logic [TASK_W-1:0]      desc_q [N];
  logic [TASK_W-1:0]      desc_d [N];
  logic [CHILD_CNT_W-1:0] pend_q [N];
  logic [CHILD_CNT_W-1:0] pend_d [N];
  logic [N-1:0]           valid_q, valid_d, issued_q, issued_d, elig;
  logic                   out_valid_q, out_valid_d;
  logic [TASK_W-1:0]      out_data_q, out_data_d;
  logic [NODE_ID_W-1:0]   out_idx_q, out_idx_d, rr_q, rr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic                   root_q, root_d;
  logic                   err_dup_q, err_dup_d, err_orphan_q, err_orphan_d, err_done_q, err_done_d;
  logic [NODE_ID_W-1:0]   sel, idx, ld_id, dn_par;
  logic [CHILD_CNT_W-1:0] ld_cc;
  logic                   found, cap, ld_hs, ld_ok, dn_ok, dec_req, dec_ok;
  assign task_in_ready  = rst_n;
  assign task_out_valid = out_valid_q;
  assign task_out_data  = out_data_q;
  assign occupancy      = occ_q;
  assign root_done      = root_q;
  assign err_dup        = err_dup_q;
  assign err_orphan     = err_orphan_q;
  assign err_done       = err_done_q;
  // a slot may run once loaded, not yet handed out, and all its children are done
  always_comb begin
    for (int i = 0; i < N; i++) elig[i] = valid_q[i] && !issued_q[i] && pend_q[i] == '0;
  end
  // pick one eligible slot: lowest index, or first after the last dispatch when round-robin
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = RR_MODE != 0 ? rr_q + NODE_ID_W'(i + 1) : NODE_ID_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  // table, output register and error next-state from loads, completions and dispatch
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    pend_d   = pend_q;
    desc_d   = desc_q;
    ld_id    = task_in_data[ID_LSB +: NODE_ID_W];
    ld_cc    = task_in_data[CC_LSB +: CHILD_CNT_W];
    ld_hs    = task_in_valid && rst_n;
    ld_ok    = ld_hs && !valid_q[ld_id];
    dn_par   = desc_q[done_id][PA_LSB +: NODE_ID_W];
    dn_ok    = done_valid && valid_q[done_id] && issued_q[done_id] && !(out_valid_q && out_idx_q == done_id);
    dec_req  = dn_ok && dn_par != '1;
    dec_ok   = dec_req && ((ld_ok && ld_id == dn_par) ? ld_cc != '0 : valid_q[dn_par] && pend_q[dn_par] != '0);
    cap      = !out_valid_q || task_out_ready;
    if (ld_ok) begin
      valid_d[ld_id]  = 1'b1;
      issued_d[ld_id] = 1'b0;
      pend_d[ld_id]   = ld_cc;
      desc_d[ld_id]   = task_in_data;
    end
    if (dn_ok) begin
      valid_d[done_id]  = 1'b0;
      issued_d[done_id] = 1'b0;
    end
    if (dec_ok) pend_d[dn_par] = pend_d[dn_par] - CHILD_CNT_W'(1);
    if (cap && found) issued_d[sel] = 1'b1;
    out_valid_d  = cap ? found : out_valid_q;
    out_data_d   = cap && found ? desc_q[sel] : out_data_q;
    out_idx_d    = cap && found ? sel : out_idx_q;
    rr_d         = cap && found ? sel : rr_q;
    occ_d        = occ_q + OW'(ld_ok) - OW'(dn_ok);
    root_d       = dn_ok && dn_par == '1;
    err_dup_d    = err_dup_q || (ld_hs && valid_q[ld_id]);
    err_done_d   = err_done_q || (done_valid && !dn_ok);
    err_orphan_d = err_orphan_q || (dec_req && !dec_ok);
  end
  // control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= '0;
      issued_q     <= '0;
      pend_q       <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      rr_q         <= '1;
      occ_q        <= '0;
      root_q       <= 1'b0;
      err_dup_q    <= 1'b0;
      err_orphan_q <= 1'b0;
      err_done_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      issued_q     <= issued_d;
      pend_q       <= pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      rr_q         <= rr_d;
      occ_q        <= occ_d;
      root_q       <= root_d;
      err_dup_q    <= err_dup_d;
      err_orphan_q <= err_orphan_d;
      err_done_q   <= err_done_d;
    end
  end
  // descriptor storage is only meaningful under a valid bit, so it needs no reset
  always_ff @(posedge clk) begin
    desc_q <= desc_d;
  end
endmodule

// File: tb/tb_gcu_task_sched.sv
// tb_gcu_task_sched: directed tests for the task scheduler in lowest-index and round-robin modes
module tb_gcu_task_sched;
  localparam int TW = 44;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, done_valid = 1'b0;
  logic          root_done, e_dup, e_orph, e_done;
  logic [TW-1:0] in_data = '0, out_data;
  logic [3:0]    done_id = '0;
  logic [4:0]    occ;
  logic          r_in_valid = 1'b0, r_in_ready, r_out_valid, r_out_ready = 1'b0, r_done_valid = 1'b0;
  logic          r_root_done, r_e_dup, r_e_orph, r_e_done;
  logic [TW-1:0] r_in_data = '0, r_out_data;
  logic [3:0]    r_done_id = '0;
  logic [4:0]    r_occ;

  gcu_task_sched #(.RR_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .task_in_valid(in_valid), .task_in_ready(in_ready), .task_in_data(in_data),
    .task_out_valid(out_valid), .task_out_ready(out_ready), .task_out_data(out_data),
    .done_valid(done_valid), .done_id(done_id), .occupancy(occ), .root_done(root_done),
    .err_dup(e_dup), .err_orphan(e_orph), .err_done(e_done)
  );

  gcu_task_sched #(.RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .task_in_valid(r_in_valid), .task_in_ready(r_in_ready), .task_in_data(r_in_data),
    .task_out_valid(r_out_valid), .task_out_ready(r_out_ready), .task_out_data(r_out_data),
    .done_valid(r_done_valid), .done_id(r_done_id), .occupancy(r_occ), .root_done(r_root_done),
    .err_dup(r_e_dup), .err_orphan(r_e_orph), .err_done(r_e_done)
  );

  function automatic logic [TW-1:0] mk(input logic [3:0] id, input logic [3:0] par, input logic [3:0] cc);
    return {id, ~id, id, par, cc, 4'h5, id, id ^ 4'h1, 4'h2, 4'h3, id ^ 4'hC};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] id, input logic [3:0] par, input logic [3:0] cc);
    in_valid = 1'b1;
    in_data  = mk(id, par, cc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dn(input logic [3:0] id);
    done_valid = 1'b1;
    done_id    = id;
    tick();
    done_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if (occ !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occ); end
    checks++; if ({root_done, e_dup, e_orph, e_done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {root_done, e_dup, e_orph, e_done}); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_leaf;
    load(4'd3, 4'hF, 4'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL leaf_latency: out_valid=%b exp 0", out_valid); end
    checks++; if (occ !== 5'd1) begin errors++; $display("FAIL leaf_occ: got %0d exp 1", occ); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd3, 4'hF, 4'd0)) begin errors++; $display("FAIL leaf_dispatch: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd3, 4'hF, 4'd0)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL leaf_drain: out_valid=%b exp 0", out_valid); end
    dn(4'd3);
    checks++; if (root_done !== 1'b1) begin errors++; $display("FAIL leaf_root_done: got %b exp 1", root_done); end
    checks++; if (occ !== 5'd0) begin errors++; $display("FAIL leaf_free_occ: got %0d exp 0", occ); end
    tick();
    checks++; if (root_done !== 1'b0) begin errors++; $display("FAIL leaf_root_pulse: got %b exp 0", root_done); end
  endtask

  task automatic test_parent;
    load(4'd5, 4'hF, 4'd2);
    load(4'd1, 4'd5, 4'd0);
    load(4'd2, 4'd5, 4'd0);
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd1, 4'd5, 4'd0)) begin errors++; $display("FAIL parent_child1: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd1, 4'd5, 4'd0)); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd2, 4'd5, 4'd0)) begin errors++; $display("FAIL parent_child2: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd2, 4'd5, 4'd0)); end
    tick();
    checks++; if (out_valid !== 1'b0 || occ !== 5'd3) begin errors++; $display("FAIL parent_waiting: valid=%b occ=%0d exp 0 3", out_valid, occ); end
    dn(4'd1);
    checks++; if (occ !== 5'd2) begin errors++; $display("FAIL parent_done1_occ: got %0d exp 2", occ); end
    dn(4'd2);
    checks++; if (out_valid !== 1'b0 || occ !== 5'd1) begin errors++; $display("FAIL parent_done2: valid=%b occ=%0d exp 0 1", out_valid, occ); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd5, 4'hF, 4'd2)) begin errors++; $display("FAIL parent_dispatch: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd5, 4'hF, 4'd2)); end
    tick();
    dn(4'd5);
    checks++; if (root_done !== 1'b1 || occ !== 5'd0) begin errors++; $display("FAIL parent_root: root=%b occ=%0d exp 1 0", root_done, occ); end
    checks++; if ({e_dup, e_orph, e_done} !== 3'b0) begin errors++; $display("FAIL parent_no_err: got %b exp 000", {e_dup, e_orph, e_done}); end
  endtask

  task automatic test_dup;
    load(4'd4, 4'hF, 4'd0);
    load(4'd4, 4'hF, 4'd0);
    checks++; if (e_dup !== 1'b1) begin errors++; $display("FAIL dup_flag: got %b exp 1", e_dup); end
    checks++; if (occ !== 5'd1) begin errors++; $display("FAIL dup_occ: got %0d exp 1", occ); end
    tick();
    dn(4'd4);
    checks++; if (occ !== 5'd0) begin errors++; $display("FAIL dup_free_occ: got %0d exp 0", occ); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    load(4'd7, 4'hF, 4'd0);
    load(4'd9, 4'hF, 4'd0);
    load(4'd10, 4'hF, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd7, 4'hF, 4'd0)) begin errors++; $display("FAIL stall_stable%0d: valid=%b data=%h exp 1 %h", i, out_valid, out_data, mk(4'd7, 4'hF, 4'd0)); end
    end
    checks++; if (occ !== 5'd3) begin errors++; $display("FAIL stall_occ: got %0d exp 3", occ); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd9, 4'hF, 4'd0)) begin errors++; $display("FAIL stall_next9: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd9, 4'hF, 4'd0)); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk(4'd10, 4'hF, 4'd0)) begin errors++; $display("FAIL stall_next10: valid=%b data=%h exp 1 %h", out_valid, out_data, mk(4'd10, 4'hF, 4'd0)); end
    tick();
    dn(4'd7);
    checks++; if (root_done !== 1'b1) begin errors++; $display("FAIL stall_root7: got %b exp 1", root_done); end
    tick();
    checks++; if (root_done !== 1'b0) begin errors++; $display("FAIL stall_root7_pulse: got %b exp 0", root_done); end
    dn(4'd9);
    dn(4'd10);
    checks++; if (occ !== 5'd0) begin errors++; $display("FAIL stall_free_occ: got %0d exp 0", occ); end
  endtask

  task automatic test_errors;
    load(4'd11, 4'd13, 4'd0);
    tick();
    tick();
    dn(4'd11);
    checks++; if (e_orph !== 1'b1 || e_done !== 1'b0) begin errors++; $display("FAIL orphan_flag: orphan=%b done=%b exp 1 0", e_orph, e_done); end
    checks++; if (occ !== 5'd0 || root_done !== 1'b0) begin errors++; $display("FAIL orphan_free: occ=%0d root=%b exp 0 0", occ, root_done); end
    out_ready = 1'b0;
    load(4'd6, 4'hF, 4'd0);
    tick();
    dn(4'd6);
    checks++; if (e_done !== 1'b1 || occ !== 5'd1) begin errors++; $display("FAIL held_done: err_done=%b occ=%0d exp 1 1", e_done, occ); end
    out_ready = 1'b1;
    tick();
    dn(4'd6);
    checks++; if (occ !== 5'd0 || root_done !== 1'b1) begin errors++; $display("FAIL held_then_done: occ=%0d root=%b exp 0 1", occ, root_done); end
  endtask

  task automatic test_round_robin;
    r_out_ready = 1'b0;
    r_in_valid  = 1'b1;
    r_in_data   = mk(4'd0, 4'hF, 4'd0);
    tick();
    r_in_data   = mk(4'd1, 4'hF, 4'd0);
    tick();
    r_in_data   = mk(4'd2, 4'hF, 4'd0);
    tick();
    r_in_valid  = 1'b0;
    checks++; if (r_out_valid !== 1'b1 || r_out_data !== mk(4'd0, 4'hF, 4'd0)) begin errors++; $display("FAIL rr_first0: valid=%b data=%h exp 1 %h", r_out_valid, r_out_data, mk(4'd0, 4'hF, 4'd0)); end
    r_out_ready = 1'b1;
    tick();
    checks++; if (r_out_data !== mk(4'd1, 4'hF, 4'd0)) begin errors++; $display("FAIL rr_then1: data=%h exp %h", r_out_data, mk(4'd1, 4'hF, 4'd0)); end
    r_out_ready  = 1'b0;
    r_done_valid = 1'b1;
    r_done_id    = 4'd0;
    tick();
    r_done_valid = 1'b0;
    checks++; if (r_occ !== 5'd2) begin errors++; $display("FAIL rr_free0_occ: got %0d exp 2", r_occ); end
    r_in_valid = 1'b1;
    r_in_data  = mk(4'd0, 4'hF, 4'd0);
    tick();
    r_in_valid = 1'b0;
    tick();
    checks++; if (r_out_valid !== 1'b1 || r_out_data !== mk(4'd1, 4'hF, 4'd0) || r_occ !== 5'd3) begin errors++; $display("FAIL rr_hold1: valid=%b data=%h occ=%0d exp 1 %h 3", r_out_valid, r_out_data, r_occ, mk(4'd1, 4'hF, 4'd0)); end
    r_out_ready = 1'b1;
    tick();
    checks++; if (r_out_valid !== 1'b1 || r_out_data !== mk(4'd2, 4'hF, 4'd0)) begin errors++; $display("FAIL rr_next2: valid=%b data=%h exp 1 %h", r_out_valid, r_out_data, mk(4'd2, 4'hF, 4'd0)); end
    tick();
    checks++; if (r_out_valid !== 1'b1 || r_out_data !== mk(4'd0, 4'hF, 4'd0)) begin errors++; $display("FAIL rr_wrap0: valid=%b data=%h exp 1 %h", r_out_valid, r_out_data, mk(4'd0, 4'hF, 4'd0)); end
    tick();
    checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: valid=%b exp 0", r_out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    load(4'd6, 4'hF, 4'd0);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: out_valid=%b exp 1", out_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || occ !== 5'd0) begin errors++; $display("FAIL rstmid_out: valid=%b data=%h occ=%0d exp 0 0 0", out_valid, out_data, occ); end
    checks++; if ({in_ready, root_done, e_dup, e_orph, e_done} !== 5'b0) begin errors++; $display("FAIL rstmid_flags: got %b exp 00000", {in_ready, root_done, e_dup, e_orph, e_done}); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || occ !== 5'd0) begin errors++; $display("FAIL rstmid_quiet%0d: valid=%b occ=%0d exp 0 0", i, out_valid, occ); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_leaf();
    test_parent();
    test_dup();
    test_stall();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcu_task_sched.md
GCU_TASK_SCHED -- requirements
Module: gcu_task_sched

Interface
Parameters:
REQ-001 The block SHALL expose parameter ADDR_W, default 4, meaning width of every address field.
REQ-002 The block SHALL expose parameter DIM_W, default 4, meaning width of total_dim and pivot_dim.
REQ-003 The block SHALL expose parameter NODE_ID_W, default 4, meaning width of node_id and parent_id; the table holds 2**NODE_ID_W slots.
REQ-004 The block SHALL expose parameter CHILD_CNT_W, default 4, meaning width of children_count.
REQ-005 The block SHALL expose parameter FLAGS_W, default 4, meaning width of flags.
REQ-006 The block SHALL expose parameter RR_MODE, default 0, meaning dispatch arbitration: 0 = lowest index, 1 = round-robin.
REQ-007 The block SHALL define TASK_W = 2*DIM_W + 2*NODE_ID_W + CHILD_CNT_W + FLAGS_W + 5*ADDR_W, with descriptor fields packed MSB-first in this order: total_dim, pivot_dim, node_id, parent_id, children_count, flags, front_addr, parent_front_addr, map_table_addr, l_factor_addr, u_factor_addr.
Ports:
REQ-008 clk  in  1  single clock; all logic is rising-edge.
REQ-009 rst_n  in  1  synchronous active-low reset.
REQ-010 task_in_valid  in  1  descriptor load request.
REQ-011 task_in_ready  out  1  load accepted when high with valid.
REQ-012 task_in_data  in  TASK_W  descriptor to load.
REQ-013 task_out_valid  out  1  ready-to-run descriptor presented.
REQ-014 task_out_ready  in  1  consumer accepts descriptor.
REQ-015 task_out_data  out  TASK_W  dispatched descriptor.
REQ-016 done_valid  in  1  node-completion notification; always accepted.
REQ-017 done_id  in  NODE_ID_W  completed node id.
REQ-018 occupancy  out  NODE_ID_W+1  number of valid slots.
REQ-019 root_done  out  1  one-cycle pulse when a node with parent_id all-ones completes.
REQ-020 err_dup, err_orphan, err_done  out  1 each  sticky error flags.

Function
REQ-021 Each slot SHALL hold descriptor, valid bit, issued bit, and pend counter (CHILD_CNT_W bits); the slot index is node_id.
REQ-022 task_in_ready SHALL be 1 whenever rst_n is high; on handshake, if the slot is free it is written with valid=1, issued=0, pend=children_count; if the slot is valid the load is dropped and err_dup set.
REQ-023 On done_valid, if slot done_id is valid and issued, the slot is freed; otherwise nothing changes and err_done is set.
REQ-024 On a legal done with parent_id not all-ones, the parent slot pend SHALL decrement by 1 if the parent is valid and pend > 0; if the parent is not valid or pend is 0, err_orphan is set and no counter changes.
REQ-025 When a load and a decrement target the same slot in one cycle, the slot SHALL be written with pend = children_count - 1 (err_orphan if children_count is 0).
REQ-026 A slot SHALL be eligible when valid=1, issued=0, pend=0.
REQ-027 The output register SHALL capture one eligible slot when task_out_valid is 0 or task_out_ready is 1, setting that slot's issued bit on the same edge; throughput is one dispatch per cycle.
REQ-028 Eligibility SHALL be evaluated on registered state: a leaf loaded at edge k appears on task_out_valid after edge k+1.
REQ-029 task_out_valid/task_out_data SHALL remain stable while task_out_valid=1 and task_out_ready=0.
REQ-030 RR_MODE=0 SHALL select the lowest eligible index; RR_MODE=1 SHALL select the first eligible index strictly after the last dispatched index, wrapping from 2**NODE_ID_W-1 to 0.
REQ-031 occupancy SHALL reflect loads and frees registered on the same edge; a simultaneous load and free leave it unchanged.
REQ-032 A done for a slot still held in the output register (not yet handshaked) SHALL set err_done and be ignored.

Reset
REQ-033 On rst_n low at a rising edge, all valid/issued bits, pend counters, the round-robin pointer (to all-ones), task_out_valid, root_done, and all error flags SHALL clear to 0, occupancy to 0, task_out_data to 0; task_in_ready SHALL be 0 while rst_n is low.
REQ-034 Reset mid-operation SHALL discard all stored and in-flight tasks without emitting a dispatch.

Verification
REQ-035 Load leaf id 3 (children 0) with task_out_ready=1 -> task_out_valid after next edge with node_id 3, occupancy 1.
REQ-036 Load parent id 5 (children 2) and leaves 1, 2 (parent 5); complete 1 and 2 -> id 5 dispatched after the edge following the second done.
REQ-037 Load id 4 twice -> second dropped, err_dup=1, occupancy 1.
REQ-038 RR_MODE=1, leaves 0, 1, 2 eligible, dispatch 1, reload 0 -> next dispatch is 2, then 0.
REQ-039 Hold task_out_ready=0 for 5 cycles with 3 eligible leaves -> data stable, one slot issued; root id 7 done -> root_done pulse one cycle.
REQ-040 Assert rst_n=0 while task_out_valid=1 -> all outputs 0 after the edge; no dispatch follows.
